// File: rtl/fpnew_pkg.sv
// Shared FP types for the fpnew datapath slice.
// Rounding-mode encoding is common to every stage that forwards or consumes it.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

endpackage

// File: rtl/fpnew_lzc_w.sv
// Leading-zero counter with an all-zero flag; the count equals WIDTH when the input is all zero.
module fpnew_lzc_w #(
  parameter int unsigned WIDTH     = 27,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
  always_comb begin
    cnt_o   = CNT_WIDTH'(WIDTH);
    empty_o = ~|in_i;
    // Scanning upward lets the highest set bit make the final assignment.
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/fpnew_norm_stage.sv
// Two-stage normalizer feeding the FP rounding stage: LZC in stage 1, shift/exponent
// update and {exp, mantissa, R, S} extraction in stage 2, with valid/ready back-pressure.
module fpnew_norm_stage
  import fpnew_pkg::*;
#(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned SUM_WIDTH = 28,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [SUM_WIDTH-1:0]         sum_i,
  input  logic [EXP_BITS+1:0]          exp_i,
  input  logic                         sticky_i,
  input  logic                         sign_i,
  input  roundmode_e                   rnd_mode_i,
  input  logic                         eff_sub_i,
  input  logic [TAG_WIDTH-1:0]         tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [EXP_BITS+MAN_BITS-1:0] abs_value_o,
  output logic [1:0]                   round_sticky_o,
  output logic                         of_o,
  output logic                         sign_o,
  output roundmode_e                   rnd_mode_o,
  output logic                         eff_sub_o,
  output logic [TAG_WIDTH-1:0]         tag_o
);

  localparam int unsigned LZC_W   = SUM_WIDTH - 1;
  localparam int unsigned CNT_W   = $clog2(LZC_W + 1);
  localparam int unsigned SCR_W   = 2 * SUM_WIDTH;
  localparam int unsigned SHAMT_W = $clog2(SCR_W);
  localparam int          RSHIFT_MAX = int'(SUM_WIDTH) + 1;

  function automatic int max_biased_exp();
    return (1 << EXP_BITS) - 1;
  endfunction

  logic s1_valid, s2_valid, s1_advance, s2_advance;

  assign s2_advance = ~s2_valid | out_ready_i;
  assign s1_advance = ~s1_valid | s2_advance;
  assign in_ready_o = s1_advance;

  // ---------------- Stage 1: capture + leading-zero count ----------------
  logic [CNT_W-1:0]     lzc_cnt;
  logic                 lzc_empty;
  logic [SUM_WIDTH-1:0] s1_sum;
  logic [EXP_BITS+1:0]  s1_exp;
  logic [CNT_W-1:0]     s1_lzc;
  logic                 s1_zero, s1_sticky, s1_sign, s1_eff_sub;
  roundmode_e           s1_rnd_mode;
  logic [TAG_WIDTH-1:0] s1_tag;

  fpnew_lzc_w #(.WIDTH(LZC_W), .CNT_WIDTH(CNT_W)) u_lzc (
    .in_i    (sum_i[SUM_WIDTH-2:0]),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_sum      <= '0;
      s1_exp      <= '0;
      s1_lzc      <= '0;
      s1_zero     <= 1'b0;
      s1_sticky   <= 1'b0;
      s1_sign     <= 1'b0;
      s1_eff_sub  <= 1'b0;
      s1_rnd_mode <= RNE;
      s1_tag      <= '0;
    end else begin
      if (s1_advance) s1_valid <= in_valid_i;
      if (in_valid_i && s1_advance) begin
        s1_sum      <= sum_i;
        s1_exp      <= exp_i;
        s1_lzc      <= lzc_cnt;
        s1_zero     <= lzc_empty;   // with the carry bit clear this means sum == 0
        s1_sticky   <= sticky_i;
        s1_sign     <= sign_i;
        s1_eff_sub  <= eff_sub_i;
        s1_rnd_mode <= rnd_mode_i;
        s1_tag      <= tag_i;
      end
    end
  end

  // ---------------- Stage 2: shift, exponent update, field extraction ----------------
  logic [SCR_W-1:0]              scr_in, scr;
  logic [SHAMT_W-1:0]            shamt;
  logic                          shifted_out, r_bit, s_bit;
  logic signed [31:0]            exp_s, exp_norm, exp_res, rshift;
  logic [MAN_BITS-1:0]           man;
  logic [EXP_BITS+MAN_BITS-1:0]  norm_abs;
  logic [1:0]                    norm_rs;
  logic                          norm_of;

  always_comb begin
    exp_s       = 32'(signed'(s1_exp));
    exp_norm    = exp_s - signed'(32'(s1_lzc));
    scr_in      = {s1_sum, {SUM_WIDTH{1'b0}}};
    scr         = scr_in;
    shamt       = '0;
    shifted_out = 1'b0;
    exp_res     = '0;
    rshift      = '0;

    if (s1_sum[SUM_WIDTH-1]) begin
      scr     = scr_in >> 1;
      exp_res = exp_s + 32'sd1;
    end else if (s1_zero) begin
      scr = '0;
    end else if (exp_norm >= 32'sd1) begin
      scr     = scr_in << s1_lzc;
      exp_res = exp_norm;
    end else if (exp_s >= 32'sd1) begin
      // Only partially normalizable: stop where the exponent field reaches the subnormal range.
      shamt = SHAMT_W'(exp_s - 32'sd1);
      scr   = scr_in << shamt;
    end else begin
      rshift      = 32'sd1 - exp_s;
      shamt       = (rshift > RSHIFT_MAX) ? SHAMT_W'(RSHIFT_MAX) : SHAMT_W'(rshift);
      scr         = scr_in >> shamt;
      shifted_out = |(scr_in & ~({SCR_W{1'b1}} << shamt));
    end

    man   = scr[SCR_W-3 -: MAN_BITS];
    r_bit = scr[SCR_W-3-MAN_BITS];
    s_bit = (|scr[SCR_W-4-MAN_BITS:0]) | shifted_out | s1_sticky;

    if (exp_res >= max_biased_exp()) begin
      norm_of  = 1'b1;
      norm_abs = {{EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      norm_rs  = 2'b00;
    end else begin
      norm_of  = 1'b0;
      norm_abs = {exp_res[EXP_BITS-1:0], man};
      norm_rs  = {r_bit, s_bit};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid       <= 1'b0;
      abs_value_o    <= '0;
      round_sticky_o <= '0;
      of_o           <= 1'b0;
      sign_o         <= 1'b0;
      rnd_mode_o     <= RNE;
      eff_sub_o      <= 1'b0;
      tag_o          <= '0;
    end else begin
      if (s2_advance) s2_valid <= s1_valid;
      if (s1_valid && s2_advance) begin
        abs_value_o    <= norm_abs;
        round_sticky_o <= norm_rs;
        of_o           <= norm_of;
        sign_o         <= s1_sign;
        rnd_mode_o     <= s1_rnd_mode;
        eff_sub_o      <= s1_eff_sub;
        tag_o          <= s1_tag;
      end
    end
  end

  assign out_valid_o = s2_valid;

endmodule
